led_pattern_ctrl: RTL and testbench
===================================

Name: led_pattern_ctrl

Overview:
Controller that sequences the 8-LED display for the board demos; it replaces a free-running counter with a mode-driven pattern engine. It contains a prescaler that generates a step tick, two debounced push-button inputs (next mode, pause), and a mode FSM that drives an 8-bit registered LED pattern. It sits between board pins (CLK, buttons) and the LED0..LED7 outputs of the top level.

Parameters:
N, 20, prescaler width; one step tick every 2^N CLK cycles.
DB_BITS, 16, debounce width; a button level must be stable 2^DB_BITS consecutive cycles to be accepted.

Ports:
CLK  input  1  system clock, all logic on rising edge
RSTN  input  1  asynchronous active-low reset
BTN_MODE  input  1  asynchronous button, active-high; press advances mode
BTN_PAUSE  input  1  asynchronous button, active-high; press toggles pause
LED  output  8  registered LED pattern, LED[0]=LED0
MODE  output  3  current mode code
PAUSED  output  1  1 while pattern is frozen
TICK  output  1  prescaler MSB square wave (prescaler[N-1])

Behaviour:
- Reset (RSTN=0, async): prescaler=0, LED=0x00, MODE=0 (UP), PAUSED=0, TICK=0, debouncer state=0, scan pos=0x01, scan dir=left.
- Prescaler: N-bit free-running up counter, wraps. step=1 for exactly one cycle when prescaler==2^N-1. Runs regardless of pause/mode.
- Buttons: 2-flop synchronizer each; debounced level updates after sync level differs from debounced level for 2^DB_BITS consecutive cycles (counter clears on any mismatch break). Event = one-cycle pulse on debounced 0->1 transition; releases produce no event.
- Mode codes: UP=0, DOWN=1, SCAN=2, BLINK=3. Mode event: UP->DOWN->SCAN->BLINK->UP.
- On mode event (applied next cycle): UP/DOWN keep current 8-bit value; entering SCAN loads LED=0x01, dir=left; entering BLINK loads LED=0x00. Mode events are accepted while paused.
- Pause event toggles PAUSED. While PAUSED=1, step is ignored; LED holds.
- Step (not paused, no mode event same cycle); LED updates in the cycle after step (latency 1):
  UP: LED+1 mod 256 (0xFF->0x00).
  DOWN: LED-1 mod 256 (0x00->0xFF).
  SCAN: one-hot bounce; shift left until 0x80, then dir=right, shift right until 0x01, then dir=left; the endpoints are shown for one step each (…0x40,0x80,0x40…).
  BLINK: LED <= ~LED (0x00 <-> 0xFF).
- Simultaneous mode event and step: mode event wins, step dropped. Simultaneous mode and pause events: both applied.
- Reset mid-operation returns to the reset state immediately; no partial button events survive.

Optional Feature:
LED_PATTERN_GRAY_EN: when defined, adds mode GRAY=4 between BLINK and UP (BLINK->GRAY->UP); an internal 8-bit binary count increments per step, LED = bin ^ (bin>>1); entering GRAY loads bin = current LED value. When undefined, MODE never exceeds 3, code 4 is unreachable, and the mode cycle is as listed above.

Test Plan:
- Reset, N=2, DB_BITS=2: after RSTN release LED=0x00, MODE=0; after 4 steps (16 CLK) LED=0x04; TICK toggles every 2 CLK.
- UP wrap: mode UP with LED=0xFF, one step -> LED=0x00; one BTN_MODE press (held 8 cycles) -> MODE=1, next step from 0x00 -> 0xFF.
- SCAN: press to MODE=2 -> LED=0x01; 14 steps -> 0x02,0x04,…,0x80,0x40,…,0x01; 15th step -> 0x02.
- Debounce: BTN_MODE glitch of 3 cycles high -> no MODE change; held 8 cycles -> exactly one advance; hold 100 cycles -> still one advance.
- Pause: in BLINK at LED=0xFF press BTN_PAUSE -> PAUSED=1, LED stays 0xFF over 10 steps; press again -> PAUSED=0, next step LED=0x00.
- Collision/reset: force mode event in the same cycle as step in UP at LED=0x10 -> MODE=1, LED=0x10 (step dropped); assert RSTN low mid-scan -> LED=0x00, MODE=0 immediately without CLK.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_ctrl
//  Description : Mode-driven LED pattern engine for the 8-LED board demo.
//                A free-running prescaler produces the step tick, two
//                synchronised and debounced push buttons select the mode and
//                toggle pause, and a mode FSM drives the registered pattern.
//                Modes: UP (0), DOWN (1), SCAN (2), BLINK (3).
//                Optional macro LED_PATTERN_GRAY_EN adds GRAY (4) between
//                BLINK and UP.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_ctrl #(
    parameter int N       = 20,
    parameter int DB_BITS = 16
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       BTN_MODE,
    input  logic       BTN_PAUSE,
    output logic [7:0] LED,
    output logic [2:0] MODE,
    output logic       PAUSED,
    output logic       TICK
);

    // Mode encodings
    localparam logic [2:0] c_MODE_UP    = 3'd0;
    localparam logic [2:0] c_MODE_DOWN  = 3'd1;
    localparam logic [2:0] c_MODE_SCAN  = 3'd2;
    localparam logic [2:0] c_MODE_BLINK = 3'd3;
`ifdef LED_PATTERN_GRAY_EN
    localparam logic [2:0] c_MODE_GRAY  = 3'd4;
`endif

    // Scan direction encodings
    localparam logic c_DIR_LEFT  = 1'b0;
    localparam logic c_DIR_RIGHT = 1'b1;

    localparam logic [N-1:0]       c_PRESC_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [DB_BITS-1:0] c_DB_ONE    = {{(DB_BITS-1){1'b0}}, 1'b1};

    logic [N-1:0] r_presc;
    logic         w_step;
    logic [1:0]   w_btn;
    logic [1:0]   w_evt;
    logic         w_mode_evt;
    logic         w_pause_evt;
    logic [2:0]   r_mode;
    logic [2:0]   w_mode_next;
    logic [7:0]   r_led;
    logic         r_dir;
    logic         r_paused;

    // Free-running prescaler; step fires on the all-ones count
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PRESC_ONE;
        end
    end

    assign w_step = &r_presc;

    // Bit 0 is the mode button, bit 1 the pause button
    assign w_btn = {BTN_PAUSE, BTN_MODE};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic               r_sync1;
            logic               r_sync2;
            logic               r_db;
            logic               r_evt;
            logic [DB_BITS-1:0] r_cnt;

            // Synchronise, debounce and emit a one-cycle press pulse.
            // The debounced level only moves after the synchronised level has
            // disagreed with it for 2^DB_BITS consecutive cycles; the pulse is
            // raised together with a 0->1 update so releases are silent.
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_db    <= 1'b0;
                    r_evt   <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_btn[gi];
                    r_sync2 <= r_sync1;
                    r_evt   <= 1'b0;
                    if (r_sync2 != r_db) begin
                        if (&r_cnt) begin
                            r_db  <= r_sync2;
                            r_evt <= r_sync2;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_DB_ONE;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            assign w_evt[gi] = r_evt;
        end
    endgenerate

    assign w_mode_evt  = w_evt[0];
    assign w_pause_evt = w_evt[1];

    // Mode sequence: UP -> DOWN -> SCAN -> BLINK (-> GRAY) -> UP
    always_comb begin
        w_mode_next = c_MODE_UP;
        case (r_mode)
            c_MODE_UP:    w_mode_next = c_MODE_DOWN;
            c_MODE_DOWN:  w_mode_next = c_MODE_SCAN;
            c_MODE_SCAN:  w_mode_next = c_MODE_BLINK;
`ifdef LED_PATTERN_GRAY_EN
            c_MODE_BLINK: w_mode_next = c_MODE_GRAY;
            c_MODE_GRAY:  w_mode_next = c_MODE_UP;
`else
            c_MODE_BLINK: w_mode_next = c_MODE_UP;
`endif
            default:      w_mode_next = c_MODE_UP;
        endcase
    end

`ifdef LED_PATTERN_GRAY_EN
    logic [7:0] r_bin;
    logic [7:0] w_bin_inc;

    assign w_bin_inc = r_bin + 8'd1;
`endif

    // Pause toggles on each pause press, independent of mode events
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_paused <= 1'b0;
        end else if (w_pause_evt) begin
            r_paused <= ~r_paused;
        end
    end

    // Mode FSM and pattern register; a mode event takes priority over a step.
    // The LED register itself holds the scan position, so SCAN entry reloads
    // it with the one-hot start value rather than keeping a separate copy.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_mode <= c_MODE_UP;
            r_led  <= 8'h00;
            r_dir  <= c_DIR_LEFT;
`ifdef LED_PATTERN_GRAY_EN
            r_bin  <= 8'h00;
`endif
        end else if (w_mode_evt) begin
            r_mode <= w_mode_next;
            case (w_mode_next)
                c_MODE_SCAN: begin
                    r_led <= 8'h01;
                    r_dir <= c_DIR_LEFT;
                end
                c_MODE_BLINK: begin
                    r_led <= 8'h00;
                end
`ifdef LED_PATTERN_GRAY_EN
                c_MODE_GRAY: begin
                    r_bin <= r_led;
                    r_led <= r_led ^ (r_led >> 1);
                end
`endif
                default: begin
                    // UP and DOWN carry the current value over
                end
            endcase
        end else if (w_step && !r_paused) begin
            case (r_mode)
                c_MODE_UP: begin
                    r_led <= r_led + 8'd1;
                end
                c_MODE_DOWN: begin
                    r_led <= r_led - 8'd1;
                end
                c_MODE_SCAN: begin
                    // Turn around on reaching an end so each end shows once
                    if (r_dir == c_DIR_LEFT) begin
                        if (r_led[7]) begin
                            r_led <= r_led >> 1;
                            r_dir <= c_DIR_RIGHT;
                        end else begin
                            r_led <= r_led << 1;
                        end
                    end else begin
                        if (r_led[0]) begin
                            r_led <= r_led << 1;
                            r_dir <= c_DIR_LEFT;
                        end else begin
                            r_led <= r_led >> 1;
                        end
                    end
                end
                c_MODE_BLINK: begin
                    r_led <= ~r_led;
                end
`ifdef LED_PATTERN_GRAY_EN
                c_MODE_GRAY: begin
                    r_bin <= w_bin_inc;
                    r_led <= w_bin_inc ^ (w_bin_inc >> 1);
                end
`endif
                default: begin
                    r_led <= r_led;
                end
            endcase
        end
    end

    assign LED    = r_led;
    assign MODE   = r_mode;
    assign PAUSED = r_paused;
    assign TICK   = r_presc[N-1];

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pattern_ctrl
//  Description : Self-checking bench for led_pattern_ctrl with N=2, DB_BITS=2
//                (step every 4 clocks, 4-cycle debounce). Default build only.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_ctrl;

    localparam int OP_STEP   = 0;   // wait arg steps
    localparam int OP_PMODE  = 1;   // press mode button for arg cycles
    localparam int OP_PPAUSE = 2;   // press pause button for arg cycles
    localparam int NV        = 28;

    typedef struct {
        int         op;
        int         arg;
        logic [7:0] led;
        logic [2:0] mode;
        logic       paused;
    } vec_t;

    typedef struct {
        logic [7:0] led;
        logic [2:0] mode;
        logic       paused;
    } exp_t;

    logic       CLK       = 1'b0;
    logic       RSTN      = 1'b0;
    logic       BTN_MODE  = 1'b0;
    logic       BTN_PAUSE = 1'b0;
    logic [7:0] LED;
    logic [2:0] MODE;
    logic       PAUSED;
    logic       TICK;

    int   pcnt  = 0;   // clock edges since reset release
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl [NV];
    exp_t sb [$];

    always #5 CLK = ~CLK;

    led_pattern_ctrl #(.N(2), .DB_BITS(2)) u_dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .BTN_MODE  (BTN_MODE),
        .BTN_PAUSE (BTN_PAUSE),
        .LED       (LED),
        .MODE      (MODE),
        .PAUSED    (PAUSED),
        .TICK      (TICK)
    );

    task automatic tick1();
        @(posedge CLK);
        pcnt++;
        #1;
    endtask

    // A step edge is the one that wraps the 2-bit prescaler back to zero
    task automatic wait_steps(input int k);
        repeat (k) begin
            do tick1(); while (pcnt % 4 != 0);
        end
    endtask

    // Called with pcnt%4==0; returns realigned after the release settles.
    // An accepted press is applied on the 7th edge after the button rises.
    task automatic press(input int which, input int hold);
        int total;
        total = ((hold + 8 + 3) / 4) * 4;
        if (which == 0) BTN_MODE = 1'b1; else BTN_PAUSE = 1'b1;
        repeat (hold) tick1();
        BTN_MODE  = 1'b0;
        BTN_PAUSE = 1'b0;
        repeat (total - hold) tick1();
    endtask

    task automatic chk(input string name, input logic [7:0] e_led,
                       input logic [2:0] e_mode, input logic e_p);
        n_vec++;
        if (LED !== e_led || MODE !== e_mode || PAUSED !== e_p) begin
            n_bad++;
            $display("FAIL %s: got LED=%h MODE=%0d PAUSED=%b, want LED=%h MODE=%0d PAUSED=%b",
                     name, LED, MODE, PAUSED, e_led, e_mode, e_p);
        end
    endtask

    task automatic chk_tick(input string name, input logic e_tick);
        n_vec++;
        if (TICK !== e_tick) begin
            n_bad++;
            $display("FAIL %s: got TICK=%b, want TICK=%b", name, TICK, e_tick);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;

        tbl[0]  = '{OP_STEP,   2,   8'h04, 3'd0, 1'b0};
        tbl[1]  = '{OP_STEP,   251, 8'hFF, 3'd0, 1'b0};
        tbl[2]  = '{OP_STEP,   1,   8'h00, 3'd0, 1'b0};
        tbl[3]  = '{OP_PMODE,  8,   8'hFE, 3'd1, 1'b0};
        tbl[4]  = '{OP_PMODE,  8,   8'h08, 3'd2, 1'b0};
        tbl[5]  = '{OP_STEP,   1,   8'h10, 3'd2, 1'b0};
        tbl[6]  = '{OP_STEP,   1,   8'h20, 3'd2, 1'b0};
        tbl[7]  = '{OP_STEP,   1,   8'h40, 3'd2, 1'b0};
        tbl[8]  = '{OP_STEP,   1,   8'h80, 3'd2, 1'b0};
        tbl[9]  = '{OP_STEP,   1,   8'h40, 3'd2, 1'b0};
        tbl[10] = '{OP_STEP,   1,   8'h20, 3'd2, 1'b0};
        tbl[11] = '{OP_STEP,   1,   8'h10, 3'd2, 1'b0};
        tbl[12] = '{OP_STEP,   1,   8'h08, 3'd2, 1'b0};
        tbl[13] = '{OP_STEP,   1,   8'h04, 3'd2, 1'b0};
        tbl[14] = '{OP_STEP,   1,   8'h02, 3'd2, 1'b0};
        tbl[15] = '{OP_STEP,   1,   8'h01, 3'd2, 1'b0};
        tbl[16] = '{OP_STEP,   1,   8'h02, 3'd2, 1'b0};
        tbl[17] = '{OP_PMODE,  3,   8'h10, 3'd2, 1'b0};
        tbl[18] = '{OP_PMODE,  100, 8'h00, 3'd3, 1'b0};
        tbl[19] = '{OP_STEP,   1,   8'hFF, 3'd3, 1'b0};
        tbl[20] = '{OP_STEP,   1,   8'h00, 3'd3, 1'b0};
        tbl[21] = '{OP_PPAUSE, 8,   8'hFF, 3'd3, 1'b1};
        tbl[22] = '{OP_STEP,   10,  8'hFF, 3'd3, 1'b1};
        tbl[23] = '{OP_PPAUSE, 8,   8'h00, 3'd3, 1'b0};
        tbl[24] = '{OP_PPAUSE, 8,   8'hFF, 3'd3, 1'b1};
        tbl[25] = '{OP_PMODE,  8,   8'hFF, 3'd0, 1'b1};
        tbl[26] = '{OP_PPAUSE, 8,   8'h02, 3'd0, 1'b0};
        tbl[27] = '{OP_STEP,   13,  8'h0F, 3'd0, 1'b0};

        // Asynchronous reset state, no clock edge needed
        #22;
        chk("reset", 8'h00, 3'd0, 1'b0);
        chk_tick("reset_tick", 1'b0);
        RSTN = 1'b1;
        pcnt = 0;

        // TICK is prescaler MSB: high for counts 2 and 3
        for (int k = 0; k < 8; k++) begin
            tick1();
            chk_tick($sformatf("tick%0d", k), (pcnt % 4) >= 2);
        end

        // Table-driven section through scoreboard
        for (int i = 0; i < NV; i++) begin
            sb.push_back('{tbl[i].led, tbl[i].mode, tbl[i].paused});
            case (tbl[i].op)
                OP_STEP:  wait_steps(tbl[i].arg);
                OP_PMODE: press(0, tbl[i].arg);
                default:  press(1, tbl[i].arg);
            endcase
            e = sb.pop_front();
            chk($sformatf("vec%0d", i), e.led, e.mode, e.paused);
        end

        // Mode event lands on the same edge as a step: step is dropped
        tick1();
        BTN_MODE = 1'b1;
        repeat (6) tick1();
        chk("pre_collide", 8'h10, 3'd0, 1'b0);
        tick1();
        chk("collide", 8'h10, 3'd1, 1'b0);
        tick1();
        BTN_MODE = 1'b0;
        wait_steps(3);
        chk("after_collide", 8'h0D, 3'd1, 1'b0);

        // Enter SCAN, then reset mid-scan with a press half debounced
        press(0, 8);
        chk("scan_entry", 8'h08, 3'd2, 1'b0);
        BTN_MODE = 1'b1;
        repeat (4) tick1();
        chk("mid_scan", 8'h10, 3'd2, 1'b0);
        #2;
        RSTN = 1'b0;
        #1;
        chk("async_reset", 8'h00, 3'd0, 1'b0);
        chk_tick("async_reset_tick", 1'b0);
        BTN_MODE = 1'b0;
        #2;
        RSTN = 1'b1;
        pcnt = 0;
        repeat (20) tick1();
        chk("post_reset", 8'h05, 3'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
